// File: rtl/rca_ls_queue.sv
// -----------------------------------------------------------------------------
// rca_ls_queue
//
// Load/store queue sitting between the RCA load/store operation units and the
// single data-memory port. Requests arrive at most one per cycle, are buffered
// in order, and are issued to memory one at a time. Only one memory operation
// is ever outstanding, so read responses return in issue order. Load results
// are lane-extracted and sign/zero-extended before being handed back.
//
// Optional feature (compile-time macro):
//   RCA_LSQ_FULL_BYPASS_EN - when defined, a full queue still accepts a new
//                            request in the same cycle the head entry pops;
//                            the new entry reuses the freed slot.
//
// Parameters:
//   XLEN   data/address width; byte enables are 4 bits, so XLEN is 32
//   DEPTH  number of queue entries (power of two, >= 2)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   addr, data      request byte address and store data
//   fn3             access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   load, store     request kind (exactly one must be set, else dropped)
//   new_request     enqueue strobe
//   lsq_full        queue cannot accept a request this cycle
//   load_data       extracted and extended load result
//   load_complete   one-cycle pulse, load_data valid
//   mem_addr        word-aligned address of the head entry
//   mem_wdata       lane-replicated store data
//   mem_be          byte enables
//   mem_rd, mem_wr  memory read / write qualifiers
//   mem_req         memory request valid
//   mem_ack         memory accepts the request in the same cycle
//   mem_rvalid      read data valid
//   mem_rdata       read data word
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rca_ls_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      fn3,
    input  logic            load,
    input  logic            store,
    input  logic            new_request,
    output logic            lsq_full,
    output logic [XLEN-1:0] load_data,
    output logic            load_complete,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic            mem_req,
    input  logic            mem_ack,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_RD = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Pick the addressed byte/halfword out of a read word and extend it.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [XLEN-1:0] word,
        input logic [2:0]      f3,
        input logic [1:0]      off
    );
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] res;
        case (off)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        // Halfword lane selected by addr[1]; addr[0] is ignored.
        if (off[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  res = {{(XLEN-8){b[7]}}, b};
            3'b001:  res = {{(XLEN-16){h[15]}}, h};
            3'b100:  res = {{(XLEN-8){1'b0}}, b};
            3'b101:  res = {{(XLEN-16){1'b0}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Byte enables for the head access; loads always read the whole word.
    function automatic logic [3:0] access_be(
        input logic       is_load,
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [3:0] be;
        if (is_load) begin
            be = 4'b1111;
        end else begin
            case (f3)
                3'b000:  be = 4'b0001 << off;
                3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    // Replicate sub-word store data across every lane so the enables alone
    // select what memory writes.
    function automatic logic [XLEN-1:0] store_lanes(
        input logic [XLEN-1:0] d,
        input logic [2:0]      f3
    );
        logic [XLEN-1:0] w;
        case (f3)
            3'b000:  w = {(XLEN/8){d[7:0]}};
            3'b001:  w = {(XLEN/16){d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // -------------------------------------------------------------------------
    // Queue storage and bookkeeping
    // -------------------------------------------------------------------------
    logic [XLEN-1:0]  q_addr_r  [DEPTH];
    logic [XLEN-1:0]  q_data_r  [DEPTH];
    logic [2:0]       q_fn3_r   [DEPTH];
    logic             q_load_r  [DEPTH];
    logic             q_store_r [DEPTH];

    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;

    state_t           state_r;
    state_t           state_n_s;

    logic [2:0]       rd_fn3_r;
    logic [1:0]       rd_off_r;
    logic [XLEN-1:0]  load_data_r;
    logic             load_complete_r;

    logic             empty_s;
    logic             req_ok_s;
    logic             push_s;
    logic             pop_s;
    logic             lsq_full_s;

    logic [XLEN-1:0]  head_addr_s;
    logic [XLEN-1:0]  head_data_s;
    logic [2:0]       head_fn3_s;
    logic             head_load_s;
    logic             head_store_s;

    logic             mem_req_s;
    logic             mem_rd_s;
    logic             mem_wr_s;
    logic [3:0]       mem_be_s;
    logic [XLEN-1:0]  mem_wdata_s;

    assign empty_s      = (count_r == {CNT_W{1'b0}});
    assign head_addr_s  = q_addr_r[head_r];
    assign head_data_s  = q_data_r[head_r];
    assign head_fn3_s   = q_fn3_r[head_r];
    assign head_load_s  = q_load_r[head_r];
    assign head_store_s = q_store_r[head_r];

    // A request that is both or neither load/store is never enqueued.
    assign req_ok_s = load ^ store;

    // The head pops whenever IDLE has something to issue and memory acks it.
    assign pop_s = (state_r == ST_IDLE) && !empty_s && mem_ack;

`ifdef RCA_LSQ_FULL_BYPASS_EN
    // A pop in the same cycle frees a slot for the incoming request.
    assign lsq_full_s = (count_r == FULL_CNT) && !pop_s;
`else
    assign lsq_full_s = (count_r == FULL_CNT);
`endif

    assign push_s = new_request && !lsq_full_s && req_ok_s;

    // Entry payload write at the tail slot; storage needs no reset because
    // count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_addr_r[tail_r]  <= addr;
            q_data_r[tail_r]  <= data;
            q_fn3_r[tail_r]   <= fn3;
            q_load_r[tail_r]  <= load;
            q_store_r[tail_r] <= store;
        end
    end

    // Head/tail pointers (natural wrap at DEPTH) and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM
    // -------------------------------------------------------------------------

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // FSM next-state logic: loads wait for their read data, stores do not.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s && head_load_s) begin
                    state_n_s = ST_WAIT_RD;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WAIT_RD: begin
                if (mem_rvalid) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_WAIT_RD;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the memory port is driven from the head entry while IDLE.
    always_comb begin
        mem_req_s   = 1'b0;
        mem_rd_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_be_s    = 4'b0000;
        mem_wdata_s = {XLEN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    mem_req_s   = 1'b1;
                    mem_rd_s    = head_load_s;
                    mem_wr_s    = head_store_s;
                    mem_be_s    = access_be(head_load_s, head_fn3_s, head_addr_s[1:0]);
                    mem_wdata_s = store_lanes(head_data_s, head_fn3_s);
                end else begin
                    mem_req_s   = 1'b0;
                end
            end
            ST_WAIT_RD: begin
                mem_req_s = 1'b0;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Remember how to extract the pending load's data once it returns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_fn3_r <= 3'b000;
            rd_off_r <= 2'b00;
        end else if (pop_s && head_load_s) begin
            rd_fn3_r <= head_fn3_s;
            rd_off_r <= head_addr_s[1:0];
        end
    end

    // Load result register and single-cycle completion pulse; read data
    // arriving outside WAIT_RD is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_data_r     <= {XLEN{1'b0}};
            load_complete_r <= 1'b0;
        end else if ((state_r == ST_WAIT_RD) && mem_rvalid) begin
            load_data_r     <= extract_load(mem_rdata, rd_fn3_r, rd_off_r);
            load_complete_r <= 1'b1;
        end else begin
            load_complete_r <= 1'b0;
        end
    end

    assign lsq_full      = lsq_full_s;
    assign load_data     = load_data_r;
    assign load_complete = load_complete_r;
    assign mem_addr      = {head_addr_s[XLEN-1:2], 2'b00};
    assign mem_wdata     = mem_wdata_s;
    assign mem_be        = mem_be_s;
    assign mem_rd        = mem_rd_s;
    assign mem_wr        = mem_wr_s;
    assign mem_req       = mem_req_s;

endmodule
